// File: rtl/mem_access.sv
// Memory-access pipeline stage: IDLE/WAIT/DONE data-memory handshake, store lane steering,
// load extraction and writeback register. Define MEM_ALIGN_CHECK_EN to trap misaligned LH/LHU/SH/LW/SW.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_RegWrite,
  input  logic        mem_lui_sig,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata_b,
  input  logic [5:0]  mem_opcode,
  input  logic [31:0] mem_imme_num,
  input  logic [4:0]  mem_wreg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        mem_addr_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        wb_regwrite_q;
  logic [4:0]  wb_wreg_q;
  logic [31:0] wb_wdata_q;

  logic        access;
  logic        misalign;
  logic        req_go;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] wb_wdata_d;
  logic        unused_imme;

  assign access      = mem_MemRead | mem_MemWrite;
  assign off         = mem_alu_result[1:0];
  assign unused_imme = ^mem_imme_num[31:16];

`ifdef MEM_ALIGN_CHECK_EN
  logic is_half;
  logic is_word;
  logic err_q;

  assign is_half      = (mem_opcode == OP_LH) || (mem_opcode == OP_LHU) || (mem_opcode == OP_SH);
  assign is_word      = (mem_opcode == OP_LW) || (mem_opcode == OP_SW);
  assign misalign     = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign mem_addr_err = err_q;
`else
  assign misalign     = 1'b0;
  assign mem_addr_err = 1'b0;
`endif

  // A misaligned access never reaches the memory and so never stalls.
  assign req_go = access & ~misalign;

  always_comb begin
    dm_req    = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        dm_req    = req_go & rst;
        mem_stall = req_go;
      end
      WAIT: begin
        dm_req    = 1'b1;
        mem_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign dm_addr = {mem_alu_result[31:2], 2'b00};
  assign dm_we   = mem_MemWrite;

  always_comb begin
    dm_be    = '1;
    dm_wdata = mem_rdata_b;
    if (mem_MemWrite) begin
      case (mem_opcode)
        OP_SB: begin
          dm_be    = 4'b0001 << off;
          dm_wdata = {4{mem_rdata_b[7:0]}};
        end
        OP_SH: begin
          dm_be    = off[1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{mem_rdata_b[15:0]}};
        end
        OP_SW:   ;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (off)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mem_opcode)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h000000, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0000, ld_half};
      OP_LW:   load_data = rdata_q;
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    if (mem_lui_sig)       wb_wdata_d = {mem_imme_num[15:0], 16'h0000};
    else if (mem_MemtoReg) wb_wdata_d = load_data;
    else                   wb_wdata_d = mem_alu_result;
  end

  // Upstream holds the instruction through DONE, so the writeback is taken from the
  // captured word at the end of DONE, when mem_stall has dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rdata_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_wreg_q     <= '0;
      wb_wdata_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_go) begin
            if (dm_ready) begin
              rdata_q <= dm_rdata;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dm_ready) begin
            rdata_q <= dm_rdata;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (mem_stall) begin
        wb_regwrite_q <= 1'b0;
      end else begin
        wb_regwrite_q <= mem_RegWrite & ~misalign;
        wb_wreg_q     <= mem_wreg;
        wb_wdata_q    <= wb_wdata_d;
      end
`ifdef MEM_ALIGN_CHECK_EN
      err_q <= misalign & ~mem_stall;
`endif
    end
  end

  assign wb_RegWrite = wb_regwrite_q;
  assign wb_wreg     = wb_wreg_q;
  assign wb_wdata    = wb_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized instructions
// checked against a word-array memory model and arithmetic lane/extension rules.
module tb_mem_access;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk, rst;
  logic        mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite, mem_lui_sig;
  logic [31:0] mem_alu_result, mem_rdata_b, mem_imme_num;
  logic [5:0]  mem_opcode;
  logic [4:0]  mem_wreg;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_stall, wb_RegWrite, mem_addr_err;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  logic [31:0] mem_model [256];
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wdata;
  bit          hold_known;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_RegWrite(mem_RegWrite), .mem_lui_sig(mem_lui_sig),
    .mem_alu_result(mem_alu_result), .mem_rdata_b(mem_rdata_b), .mem_opcode(mem_opcode),
    .mem_imme_num(mem_imme_num), .mem_wreg(mem_wreg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .wb_RegWrite(wb_RegWrite), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .mem_addr_err(mem_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst && dm_req && dm_ready) hs_count++;

  function automatic bit misaligned_f(input logic [5:0] op, input logic [31:0] a);
    bit chk;
`ifdef MEM_ALIGN_CHECK_EN
    chk = 1'b1;
`else
    chk = 1'b0;
`endif
    return chk && (((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 != 0)) ||
                   ((op == OP_LW || op == OP_SW) && (a % 4 != 0)));
  endfunction

  function automatic logic [31:0] load_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 128) ? b + 32'hFFFFFF00 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h + 32'hFFFF0000 : h;
      OP_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [5:0] op, input logic [31:0] a, input bit wr);
    if (!wr) return 4'hF;
    case (op)
      OP_SB:   return 4'((1 << (a % 4)));
      OP_SH:   return ((a % 4) >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [5:0] op, input logic [31:0] rb);
    case (op)
      OP_SB:   return (rb & 32'hFF) * 32'h01010101;
      OP_SH:   return (rb & 32'hFFFF) * 32'h00010001;
      default: return rb;
    endcase
  endfunction

  // Called just after a posedge; returns just after the posedge that retires the instruction.
  task automatic do_instr(input bit rd, input bit wr, input bit m2r, input bit rw, input bit lui,
                          input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rb,
                          input logic [31:0] imm, input logic [4:0] wreg, input int lat);
    logic [31:0] word, exp_val, ewd;
    logic [3:0]  ebe;
    bit          acc, mis, got;
    int          stalls, idx;
    idx  = (alu >> 2) % 256;
    word = mem_model[idx];
    acc  = rd || wr;
    mis  = acc && misaligned_f(op, alu);
    ebe  = be_f(op, alu, wr);
    ewd  = wdata_f(op, rb);
    if (lui)      exp_val = (imm & 32'hFFFF) << 16;
    else if (m2r) exp_val = load_f(op, alu, word);
    else          exp_val = alu;
    mem_MemRead = rd; mem_MemWrite = wr; mem_MemtoReg = m2r; mem_RegWrite = rw; mem_lui_sig = lui;
    mem_opcode = op; mem_alu_result = alu; mem_rdata_b = rb; mem_imme_num = imm; mem_wreg = wreg;
    dm_ready = 1'b0;
    if (!acc || mis) begin
      #1;
      if (mem_stall !== 1'b0) begin $display("FAIL nomem_stall: got %b exp 0", mem_stall); n_fail++; end
      n_checks++;
      if (dm_req !== 1'b0) begin $display("FAIL nomem_req: got %b exp 0", dm_req); n_fail++; end
      n_checks++;
      @(posedge clk); #1;
    end else begin
      stalls = 0; got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        dm_ready = (c >= lat);
        dm_rdata = word;
        #1;
        if (dm_req !== 1'b1 || mem_stall !== 1'b1) begin
          $display("FAIL req_stall: got req=%b stall=%b exp 1/1", dm_req, mem_stall); n_fail++;
        end
        n_checks++;
        if (dm_addr !== (alu & 32'hFFFFFFFC) || dm_we !== wr || dm_be !== ebe) begin
          $display("FAIL dm_ctrl: got addr=%h we=%b be=%b exp %h/%b/%b", dm_addr, dm_we, dm_be,
                   alu & 32'hFFFFFFFC, wr, ebe); n_fail++;
        end
        n_checks++;
        if (wr) begin
          if (dm_wdata !== ewd) begin $display("FAIL dm_wdata: got %h exp %h", dm_wdata, ewd); n_fail++; end
          n_checks++;
        end
        stalls++;
        got = dm_ready;
        @(posedge clk); #1;
        if (wb_RegWrite !== 1'b0) begin $display("FAIL bubble: got wb_RegWrite=%b exp 0", wb_RegWrite); n_fail++; end
        n_checks++;
        if (hold_known) begin
          if (wb_wreg !== exp_wreg || wb_wdata !== exp_wdata) begin
            $display("FAIL hold: got %0d/%h exp %0d/%h", wb_wreg, wb_wdata, exp_wreg, exp_wdata); n_fail++;
          end
          n_checks++;
        end
        if (got) break;
      end
      if (!got) begin $display("FAIL ready_timeout: got no completion exp completion"); n_fail++; end
      n_checks++;
      dm_ready = 1'b0;
      dm_rdata = $urandom;
      #1;
      if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin
        $display("FAIL done_state: got req=%b stall=%b exp 0/0", dm_req, mem_stall); n_fail++;
      end
      n_checks++;
      if (stalls != lat + 1) begin $display("FAIL stall_count: got %0d exp %0d", stalls, lat + 1); n_fail++; end
      n_checks++;
      @(posedge clk); #1;
      if (wr) for (int i = 0; i < 4; i++) if (ebe[i]) mem_model[idx][8*i +: 8] = ewd[8*i +: 8];
    end
    if (wb_RegWrite !== (rw && !mis)) begin
      $display("FAIL wb_regwrite: got %b exp %b", wb_RegWrite, rw && !mis); n_fail++;
    end
    n_checks++;
    if (!mis) begin
      if (wb_wreg !== wreg || wb_wdata !== exp_val) begin
        $display("FAIL wb_data: op=%h got %0d/%h exp %0d/%h", op, wb_wreg, wb_wdata, wreg, exp_val); n_fail++;
      end
      n_checks++;
    end
    if (mem_addr_err !== mis) begin $display("FAIL addr_err: got %b exp %b", mem_addr_err, mis); n_fail++; end
    n_checks++;
    exp_wreg = wreg; exp_wdata = exp_val; hold_known = !mis;
  endtask

  task automatic nop();
    do_instr(0, 0, 0, 0, 0, OP_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_MemRead = 0; mem_MemWrite = 0; mem_MemtoReg = 0; mem_RegWrite = 1; mem_lui_sig = 0;
    mem_opcode = OP_ADD; mem_alu_result = 32'hDEAD_BEEF; mem_rdata_b = 0; mem_imme_num = 0;
    mem_wreg = 5'd9; dm_ready = 0; dm_rdata = 0;
    #1 rst = 1'b0;
    #1;
    if (wb_RegWrite !== 1'b0 || wb_wreg !== 5'd0 || wb_wdata !== 32'h0 || mem_addr_err !== 1'b0) begin
      $display("FAIL reset_async: got %b/%0d/%h/%b exp all 0", wb_RegWrite, wb_wreg, wb_wdata, mem_addr_err);
      n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (wb_RegWrite !== 1'b0 || wb_wdata !== 32'h0 || dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      $display("FAIL reset_held: got %b/%h/%b/%b exp all 0", wb_RegWrite, wb_wdata, dm_req, mem_stall);
      n_fail++;
    end
    n_checks++;
    rst = 1'b1;
    exp_wreg = 0; exp_wdata = 0; hold_known = 1'b1;
  endtask

  task automatic test_directed();
    do_instr(0, 0, 0, 1, 0, OP_ADD, 32'h1234, 32'h0, 32'h0, 5'd5, 0);
    mem_model[(32'h103 >> 2) % 256] = 32'h80FFFFFF;
    do_instr(1, 0, 1, 1, 0, OP_LB, 32'h103, 32'h0, 32'h0, 5'd6, 3);
    if (wb_wdata !== 32'hFFFFFF80) begin $display("FAIL lb_value: got %h exp FFFFFF80", wb_wdata); n_fail++; end
    n_checks++;
    mem_model[(32'h200 >> 2) % 256] = 32'h11223344;
    do_instr(0, 1, 0, 0, 0, OP_SH, 32'h202, 32'hAAAA5678, 32'h0, 5'd0, 0);
    if (mem_model[(32'h200 >> 2) % 256] !== 32'h56783344) begin
      $display("FAIL sh_merge: got %h exp 56783344", mem_model[(32'h200 >> 2) % 256]); n_fail++;
    end
    n_checks++;
    do_instr(0, 0, 0, 1, 1, OP_ADD, 32'h5555, 32'h0, 32'h0000ABCD, 5'd3, 0);
    if (wb_wdata !== 32'hABCD0000) begin $display("FAIL lui_value: got %h exp ABCD0000", wb_wdata); n_fail++; end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int h0;
    h0 = hs_count;
    do_instr(1, 0, 1, 1, 0, OP_LW, 32'h100, 32'h0, 32'h0, 5'd10, 1);
    do_instr(1, 0, 1, 1, 0, OP_LW, 32'h104, 32'h0, 32'h0, 5'd11, 0);
    if (hs_count - h0 != 2) begin $display("FAIL b2b_requests: got %0d exp 2", hs_count - h0); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid_wait();
    mem_MemRead = 1; mem_MemWrite = 0; mem_MemtoReg = 1; mem_RegWrite = 1; mem_lui_sig = 0;
    mem_opcode = OP_LW; mem_alu_result = 32'h40; mem_wreg = 5'd7; dm_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    if (dm_req !== 1'b0) begin $display("FAIL rst_drops_req: got %b exp 0", dm_req); n_fail++; end
    n_checks++;
    if (wb_RegWrite !== 1'b0 || wb_wreg !== 5'd0 || wb_wdata !== 32'h0) begin
      $display("FAIL rst_wb_clear: got %b/%0d/%h exp 0/0/0", wb_RegWrite, wb_wreg, wb_wdata); n_fail++;
    end
    n_checks++;
    mem_MemRead = 0; mem_MemtoReg = 0; mem_RegWrite = 0; mem_alu_result = 0; mem_wreg = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    if (wb_RegWrite !== 1'b0 || wb_wdata !== 32'h0 || dm_req !== 1'b0) begin
      $display("FAIL abandoned_wb: got %b/%h/%b exp 0/0/0", wb_RegWrite, wb_wdata, dm_req); n_fail++;
    end
    n_checks++;
    exp_wreg = 0; exp_wdata = 0; hold_known = 1'b1;
  endtask

  task automatic test_misalign();
    int h0;
    h0 = hs_count;
    do_instr(1, 0, 1, 1, 0, OP_LW, 32'h6, 32'h0, 32'h0, 5'd12, 1);
    do_instr(0, 0, 0, 1, 0, OP_ADD, 32'h77, 32'h0, 32'h0, 5'd13, 0);
`ifdef MEM_ALIGN_CHECK_EN
    if (hs_count != h0) begin $display("FAIL misalign_req: got %0d exp 0", hs_count - h0); n_fail++; end
`else
    if (hs_count != h0 + 1) begin $display("FAIL misalign_req: got %0d exp 1", hs_count - h0); n_fail++; end
`endif
    n_checks++;
  endtask

  task automatic test_random();
    logic [5:0] ld_ops [5];
    logic [5:0] st_ops [3];
    int sel;
    ld_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    st_ops = '{OP_SB, OP_SH, OP_SW};
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)
        do_instr(0, 0, 0, 1'($urandom_range(0, 1)), 0, OP_ADD, $urandom, $urandom, $urandom,
                 5'($urandom_range(1, 31)), 0);
      else if (sel == 1)
        do_instr(0, 0, 0, 1, 1, OP_ADD, $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 0);
      else if (sel <= 6)
        do_instr(1, 0, 1, 1, 0, ld_ops[sel-2], 32'h100 + $urandom_range(0, 255), $urandom, $urandom,
                 5'($urandom_range(1, 31)), $urandom_range(0, 3));
      else
        do_instr(0, 1, 0, 0, 0, st_ops[sel-7], 32'h100 + $urandom_range(0, 255), $urandom, $urandom,
                 5'($urandom_range(1, 31)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    test_reset();
    @(posedge clk); #1;
    test_directed();
    test_back_to_back();
    test_reset_mid_wait();
    test_misalign();
    test_random();
    nop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL provide ports: clk in 1, pipeline clock; rst in 1, asynchronous active-low reset.
REQ-002 SHALL accept stage inputs: mem_MemRead/mem_MemWrite/mem_MemtoReg/mem_RegWrite/mem_lui_sig in 1 each; mem_alu_result in 32, address or ALU value; mem_rdata_b in 32, store data; mem_opcode in 6; mem_imme_num in 32; mem_wreg in 5.
REQ-003 SHALL drive the data-memory port: dm_req out 1, access request; dm_we out 1, write; dm_addr out 32, word address; dm_be out 4, byte enables; dm_wdata out 32; dm_ready in 1, completion; dm_rdata in 32, read word.
REQ-004 SHALL drive: mem_stall out 1, freeze upstream; wb_RegWrite out 1; wb_wreg out 5; wb_wdata out 32; mem_addr_err out 1, misalignment pulse.

Function
REQ-005 SHALL use FSM states IDLE, WAIT, DONE; access = mem_MemRead | mem_MemWrite.
REQ-006 IDLE: access and dm_ready=0 -> WAIT; access and dm_ready=1 -> DONE, capturing dm_rdata; otherwise stay in IDLE.
REQ-007 WAIT: hold all dm_* outputs stable; dm_ready=1 -> DONE, capturing dm_rdata; otherwise stay in WAIT.
REQ-008 DONE -> IDLE unconditionally; DONE SHALL NOT issue dm_req, so one instruction never gets a second request.
REQ-009 dm_req = access in IDLE, 1 in WAIT, 0 in DONE; mem_stall = (IDLE and access) or WAIT, combinational.
REQ-010 dm_addr = {mem_alu_result[31:2],2'b00}; dm_we = mem_MemWrite.
REQ-011 Stores, little-endian: SB(0x28) be=1<<addr[1:0], wdata=4 copies of rdata_b[7:0]; SH(0x29) be=addr[1]?1100:0011, wdata=2 copies of rdata_b[15:0]; SW(0x2B) be=1111, wdata=rdata_b.
REQ-012 Loads select the lane from the captured word by addr[1:0]: LB(0x20) and LH(0x21) sign-extend; LBU(0x24) and LHU(0x25) zero-extend; LW(0x23) takes the full word; dm_be=1111 on reads.
REQ-013 Writeback select: mem_lui_sig -> {mem_imme_num[15:0],16'h0000}; else mem_MemtoReg -> extracted load data; else mem_alu_result.
REQ-014 wb_RegWrite, wb_wreg and wb_wdata SHALL be registered at every posedge where mem_stall=0.
REQ-015 Writeback latency: 1 cycle for a non-memory instruction; for a memory access, the wb outputs update at the end of the DONE cycle.
REQ-016 While mem_stall=1, the wb registers SHALL capture wb_RegWrite=0, a bubble, and wb_wreg/wb_wdata SHALL hold.
REQ-017 Back-to-back accesses: the instruction after DONE SHALL start a fresh IDLE request; there is no idle gap beyond DONE.

Reset
REQ-018 rst=0 SHALL immediately force state=IDLE, wb_RegWrite=0, wb_wreg=0, wb_wdata=0, captured data=0 and mem_addr_err=0, independent of clk.
REQ-019 Reset during WAIT SHALL abandon the access; dm_req follows the stage inputs from IDLE and no writeback is produced for the abandoned access.

Configuration
REQ-020 Macro MEM_ALIGN_CHECK_EN: when defined, LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 SHALL be treated as misaligned accesses.
REQ-021 For a misaligned access, dm_req SHALL stay 0, there SHALL be no stall, wb_RegWrite SHALL be 0, and mem_addr_err SHALL pulse high 1 cycle after that instruction is accepted.
REQ-022 When MEM_ALIGN_CHECK_EN is undefined: mem_addr_err SHALL be tied 0; halfword accesses use addr[1] only; word accesses ignore addr[1:0].

Verification
REQ-023 ADD: alu_result=0x1234, RegWrite=1, wreg=5, no access -> next cycle wb_wreg=5, wb_wdata=0x1234, mem_stall never 1.
REQ-024 LB at addr 0x103, dm_rdata=0x80FFFFFF, dm_ready asserted 3 cycles after dm_req -> dm_addr=0x100 and be=1111; mem_stall high 4 cycles; wb_wdata=0xFFFFFF80.
REQ-025 SH at addr 0x202, rdata_b=0xAAAA5678, dm_ready=1 in the first cycle -> dm_be=1100, dm_wdata=0x56785678, exactly 1 stall cycle, wb_RegWrite=0.
REQ-026 LUI: lui_sig=1, imme_num=0x0000ABCD -> wb_wdata=0xABCD0000; back-to-back LW, LW -> exactly two dm_req transactions, no duplicates.
REQ-027 rst pulled low mid-WAIT -> dm_req drops without a clk edge; state=IDLE; all wb outputs 0; then with MEM_ALIGN_CHECK_EN, LW at 0x6 -> no dm_req, mem_addr_err pulses once.
